dram_timing_scheduler: RTL and testbench

//  Timing and refresh scheduler for the DRAM command FSM. Watches the FSM's current

---
 rtl/dram_pkg.sv | 13 +
 rtl/dram_timing_scheduler.sv | 140 ++++++++++++++
 tb/tb_dram_timing_scheduler.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_pkg.sv
// Shared DRAM command-FSM state encoding, used by the command FSM and its timing scheduler.
package dram_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ACTIVATE  = 3'd1,
    READ      = 3'd2,
    WRITE     = 3'd3,
    PRECHARGE = 3'd4,
    REFRESH   = 3'd5
  } dram_state_t;

endpackage

// File: rtl/dram_timing_scheduler.sv
// Timing/refresh scheduler: per-command tX_done strobes and refresh bookkeeping for the command FSM.
// Optional feature macro DRAM_REF_URGENT_EN adds ref_urgent and sticky ref_overflow outputs.
module dram_timing_scheduler
  import dram_pkg::*;
#(
  parameter int T_RCD    = 14,
  parameter int T_RD     = 20,
  parameter int T_WR     = 30,
  parameter int T_RP     = 14,
  parameter int T_RFC    = 350,
  parameter int T_REFI   = 7800,
  parameter int MAX_PEND = 8,
  parameter int CNT_W    = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  dram_state_t cmd_state,
  output logic        tACT_done,
  output logic        tRD_done,
  output logic        tWR_done,
  output logic        tPRE_done,
  output logic        tREF_done,
  output logic        rf_req,
  output logic [3:0]  rf_pending
`ifdef DRAM_REF_URGENT_EN
  ,
  output logic        ref_urgent,
  output logic        ref_overflow
`endif
);

  localparam longint CNT_RANGE = longint'(1) <<< CNT_W;

  if (T_RCD < 1 || T_RD < 1 || T_WR < 1 || T_RP < 1 || T_RFC < 1 || T_REFI < 1) begin : g_bad_timing
    $fatal(1, "dram_timing_scheduler: every T_* parameter must be >= 1");
  end

  if (MAX_PEND < 2 || MAX_PEND > 15) begin : g_bad_pend
    $fatal(1, "dram_timing_scheduler: MAX_PEND must be in 2..15");
  end

  if (longint'(T_RCD) > CNT_RANGE || longint'(T_RD) > CNT_RANGE || longint'(T_WR) > CNT_RANGE ||
      longint'(T_RP) > CNT_RANGE || longint'(T_RFC) > CNT_RANGE || longint'(T_REFI) > CNT_RANGE)
  begin : g_bad_cnt_w
    $fatal(1, "dram_timing_scheduler: CNT_W too narrow for the timing parameters");
  end

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] RCD_LAST  = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(T_RD - 1);
  localparam logic [CNT_W-1:0] WR_LAST   = CNT_W'(T_WR - 1);
  localparam logic [CNT_W-1:0] RP_LAST   = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] RFC_LAST  = CNT_W'(T_RFC - 1);
  localparam logic [CNT_W-1:0] REFI_LAST = CNT_W'(T_REFI - 1);
  localparam logic [3:0]       PEND_MAX  = 4'(MAX_PEND);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // A wrap and a completed refresh in the same cycle cancel out.
  function automatic logic [3:0] pend_step(input logic [3:0] p, input logic up, input logic down);
    logic [3:0] r;
    r = p;
    if (up && !down && p != PEND_MAX) r = p + 4'd1;
    if (down && !up && p != 4'd0)     r = p - 4'd1;
    return r;
  endfunction

  dram_state_t      prev_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_cur;
  logic [CNT_W-1:0] refi_cnt;
  logic [3:0]       pending;
  logic [3:0]       pend_next;
  logic             entry;
  logic             refi_wrap;
  logic             act_hit;
  logic             rd_hit;
  logic             wr_hit;
  logic             pre_hit;
  logic             ref_hit;

  // Combinational view of the current cycle: phase count, done conditions, owed-refresh update.
  always_comb begin
    entry     = (cmd_state != prev_state);
    cnt_cur   = entry ? '0 : cnt;
    act_hit   = (cmd_state == ACTIVATE)  && (cnt_cur == RCD_LAST);
    rd_hit    = (cmd_state == READ)      && (cnt_cur == RD_LAST);
    wr_hit    = (cmd_state == WRITE)     && (cnt_cur == WR_LAST);
    pre_hit   = (cmd_state == PRECHARGE) && (cnt_cur == RP_LAST);
    ref_hit   = (cmd_state == REFRESH)   && (cnt_cur == RFC_LAST);
    refi_wrap = (refi_cnt == REFI_LAST);
    pend_next = pend_step(pending, refi_wrap, tREF_done);
  end

  // Registered state and outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prev_state <= IDLE;
      cnt        <= '0;
      refi_cnt   <= '0;
      pending    <= '0;
      rf_req     <= 1'b0;
      tACT_done  <= 1'b0;
      tRD_done   <= 1'b0;
      tWR_done   <= 1'b0;
      tPRE_done  <= 1'b0;
      tREF_done  <= 1'b0;
    end else begin
      prev_state <= cmd_state;
      cnt        <= sat_inc(cnt_cur);
      refi_cnt   <= refi_wrap ? '0 : refi_cnt + CNT_ONE;
      pending    <= pend_next;
      rf_req     <= (pend_next != 4'd0);
      tACT_done  <= act_hit;
      tRD_done   <= rd_hit;
      tWR_done   <= wr_hit;
      tPRE_done  <= pre_hit;
      tREF_done  <= ref_hit;
    end
  end

  assign rf_pending = pending;

`ifdef DRAM_REF_URGENT_EN
  // Urgency tracks the updated owed count; overflow latches a wrap that found the queue full.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ref_urgent   <= 1'b0;
      ref_overflow <= 1'b0;
    end else begin
      ref_urgent   <= (pend_next >= PEND_MAX - 4'd1);
      ref_overflow <= ref_overflow | (refi_wrap && (pending == PEND_MAX));
    end
  end
`endif

endmodule

// File: tb/tb_dram_timing_scheduler.sv
// Self-checking bench for dram_timing_scheduler: directed scenarios plus random state sequences vs a reference model.
module tb_dram_timing_scheduler;
  import dram_pkg::*;

  localparam int T_RCD    = 14;
  localparam int T_RD     = 20;
  localparam int T_WR     = 30;
  localparam int T_RP     = 14;
  localparam int T_RFC    = 10;
  localparam int T_REFI   = 100;
  localparam int MAX_PEND = 4;
  localparam int CNT_W    = 16;

  logic        CLK = 1'b0;
  logic        RST;
  dram_state_t cmd_state;
  logic        tACT_done, tRD_done, tWR_done, tPRE_done, tREF_done, rf_req;
  logic [3:0]  rf_pending;
`ifdef DRAM_REF_URGENT_EN
  logic        ref_urgent, ref_overflow;
`endif

  dram_timing_scheduler #(
    .T_RCD(T_RCD), .T_RD(T_RD), .T_WR(T_WR), .T_RP(T_RP), .T_RFC(T_RFC),
    .T_REFI(T_REFI), .MAX_PEND(MAX_PEND), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .cmd_state(cmd_state),
    .tACT_done(tACT_done),
    .tRD_done(tRD_done),
    .tWR_done(tWR_done),
    .tPRE_done(tPRE_done),
    .tREF_done(tREF_done),
    .rf_req(rf_req),
    .rf_pending(rf_pending)
`ifdef DRAM_REF_URGENT_EN
    ,
    .ref_urgent(ref_urgent),
    .ref_overflow(ref_overflow)
`endif
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: run length of the driven state, cycle index since reset, owed refreshes.
  dram_state_t m_last;
  int          run;
  int          n;
  int          m_pend;
  bit          e_act, e_rd, e_wr, e_pre, e_ref;
`ifdef DRAM_REF_URGENT_EN
  bit          e_urg, e_ovf;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last = IDLE;
    run    = 0;
    n      = 0;
    m_pend = 0;
    e_act  = 0; e_rd = 0; e_wr = 0; e_pre = 0; e_ref = 0;
`ifdef DRAM_REF_URGENT_EN
    e_urg  = 0; e_ovf = 0;
`endif
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_act"}, tACT_done, 0);
    check({tag, "_rd"}, tRD_done, 0);
    check({tag, "_wr"}, tWR_done, 0);
    check({tag, "_pre"}, tPRE_done, 0);
    check({tag, "_ref"}, tREF_done, 0);
    check({tag, "_rf_req"}, rf_req, 0);
    check({tag, "_rf_pending"}, rf_pending, 0);
`ifdef DRAM_REF_URGENT_EN
    check({tag, "_urgent"}, ref_urgent, 0);
    check({tag, "_overflow"}, ref_overflow, 0);
`endif
  endtask

  task automatic check_all();
    check($sformatf("act@%0d", n), tACT_done, e_act);
    check($sformatf("rd@%0d", n), tRD_done, e_rd);
    check($sformatf("wr@%0d", n), tWR_done, e_wr);
    check($sformatf("pre@%0d", n), tPRE_done, e_pre);
    check($sformatf("ref@%0d", n), tREF_done, e_ref);
    check($sformatf("rf_req@%0d", n), rf_req, (m_pend != 0));
    check($sformatf("rf_pending@%0d", n), rf_pending, m_pend);
`ifdef DRAM_REF_URGENT_EN
    check($sformatf("urgent@%0d", n), ref_urgent, e_urg);
    check($sformatf("overflow@%0d", n), ref_overflow, e_ovf);
`endif
  endtask

  // Drive one cycle of cmd_state, predict the registered outputs, compare after the edge.
  task automatic tick(input dram_state_t s);
    bit wrap;
    cmd_state = s;
    run    = (s == m_last) ? run + 1 : 1;
    m_last = s;
    wrap   = ((n % T_REFI) == T_REFI - 1);
`ifdef DRAM_REF_URGENT_EN
    if (wrap && m_pend == MAX_PEND) e_ovf = 1;
`endif
    m_pend = m_pend + int'(wrap) - int'(e_ref);
    if (m_pend > MAX_PEND) m_pend = MAX_PEND;
    if (m_pend < 0) m_pend = 0;
    e_act = (s == ACTIVATE)  && (run == T_RCD);
    e_rd  = (s == READ)      && (run == T_RD);
    e_wr  = (s == WRITE)     && (run == T_WR);
    e_pre = (s == PRECHARGE) && (run == T_RP);
    e_ref = (s == REFRESH)   && (run == T_RFC);
`ifdef DRAM_REF_URGENT_EN
    e_urg = (m_pend >= MAX_PEND - 1);
`endif
    n++;
    @(posedge CLK);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    cmd_state = IDLE;
    repeat (3) @(posedge CLK);
    #1;
    check_zero("rst");
    RST = 1'b0;
    model_reset();
  endtask

  function automatic int t_of(input dram_state_t s);
    case (s)
      ACTIVATE:  return T_RCD;
      READ:      return T_RD;
      WRITE:     return T_WR;
      PRECHARGE: return T_RP;
      REFRESH:   return T_RFC;
      default:   return 5;
    endcase
  endfunction

  initial begin
    int cnt_a, pos_a, cnt_b;
    RST = 1'b1;
    cmd_state = IDLE;
    model_reset();

    // Reset and ACTIVATE timing
    do_reset();
    tick(IDLE);
    cnt_a = 0; pos_a = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(ACTIVATE);
      if (tACT_done === 1'b1) begin cnt_a++; pos_a = i + 1; end
    end
    check("act_pulses", cnt_a, 1);
    check("act_cycle", pos_a, 15);
    repeat (2) tick(IDLE);

    // Early exit from WRITE, then a full visit
    cnt_b = 0;
    for (int i = 1; i <= 10; i++) begin
      tick(WRITE);
      if (tWR_done === 1'b1) cnt_b++;
    end
    tick(IDLE);
    check("wr_first_visit", cnt_b, 0);
    cnt_a = 0; pos_a = 0;
    for (int i = 1; i <= 35; i++) begin
      tick(WRITE);
      if (tWR_done === 1'b1) begin cnt_a++; pos_a = i; end
    end
    check("wr_pulses", cnt_a, 1);
    check("wr_pos", pos_a, 30);

    // First refresh interval and its completion
    do_reset();
    while (n < T_REFI) tick(IDLE);
    check("refi_pending", rf_pending, 1);
    check("refi_req", rf_req, 1);
    repeat (T_RFC) tick(REFRESH);
    check("ref_done", tREF_done, 1);
    tick(IDLE);
    check("ref_req_drop", rf_req, 0);
    check("ref_pend_drop", rf_pending, 0);

    // Postponement up to saturation
    do_reset();
    while (n < 5 * T_REFI - 1) begin
      tick(IDLE);
      if (n % T_REFI == 0)
        check($sformatf("pend_step@%0d", n), rf_pending, (n / T_REFI > MAX_PEND) ? MAX_PEND : n / T_REFI);
    end
`ifdef DRAM_REF_URGENT_EN
    check("overflow_before", ref_overflow, 0);
    check("urgent_full", ref_urgent, 1);
`endif
    tick(IDLE);
    check("pend_hold", rf_pending, MAX_PEND);
`ifdef DRAM_REF_URGENT_EN
    check("overflow_after", ref_overflow, 1);
`endif
    repeat (5) tick(IDLE);

    // Wrap coinciding with a refresh completion, then async reset mid-REFRESH
    do_reset();
    while (n < 3 * T_REFI - 1 - T_RFC) tick(IDLE);
    check("coll_pend_pre", rf_pending, 2);
    repeat (T_RFC) tick(REFRESH);
    check("coll_done", tREF_done, 1);
    tick(IDLE);
    check("coll_pend", rf_pending, 2);
    repeat (T_RFC) tick(REFRESH);
    check("async_pre_done", tREF_done, 1);
    check("async_pre_pend", rf_pending, 2);
    #2;
    RST = 1'b1;
    #1;
    check_zero("async");
    do_reset();

    // Random state sequences with hold lengths clustered around the timing boundaries
    while (n < 3500) begin
      dram_state_t s;
      int len;
      s = dram_state_t'($urandom_range(0, 5));
      if ($urandom_range(0, 1) == 1)
        len = t_of(s) + int'($urandom_range(0, 4)) - 2;
      else
        len = int'($urandom_range(1, 40));
      if (len < 1) len = 1;
      repeat (len) tick(s);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
